// File: rtl/pipe_pkg.sv
// Shared types and constants for the generic inter-stage pipeline register.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  // Default widths for each stage boundary of the core.
  localparam int IFID_CTRL_W  = 4;
  localparam int IFID_DATA_W  = 64;
  localparam int IDEX_CTRL_W  = 8;
  localparam int IDEX_DATA_W  = 128;
  localparam int EXMEM_CTRL_W = 6;
  localparam int EXMEM_DATA_W = 112;
  localparam int MEMWB_CTRL_W = 3;
  localparam int MEMWB_DATA_W = 72;

  // Maps an FSM state onto the number of entries it holds.
  function automatic logic [1:0] occOf(pipe_state_e s);
    logic [1:0] occ;
    occ = OCC_EMPTY;
    case (s)
      ONE:     occ = OCC_ONE;
      TWO:     occ = OCC_TWO;
      default: occ = OCC_EMPTY;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One entry of the stage register: a valid bit plus control and payload.
// clear kills the entry (and optionally its data), load captures a new
// entry, drop retires it as a bubble while leaving the payload untouched.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int CTRL_W     = IDEX_CTRL_W,
  parameter int DATA_W     = IDEX_DATA_W,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              drop_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  // Entry storage: clear beats load beats drop; data only moves on load or a clearing kill.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      if (CLEAR_DATA) data_q <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
    end else if (drop_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register with a two-entry skid buffer so that
// ready_o is a function of registered state only, plus a synchronous flush
// and a saturating count of flushes that actually killed something.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W     = IDEX_CTRL_W,
  parameter int DATA_W     = IDEX_DATA_W,
  parameter bit CLEAR_DATA = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  pipe_state_e state_q, state_d;
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

  logic acc, rel;
  logic mainLoad, mainDrop, mainFromSkid;
  logic skidLoad, skidDrop, clearAll;
  logic mainValid, skidValid;
  logic [CTRL_W-1:0] mainCtrlIn, skidCtrl;
  logic [DATA_W-1:0] mainDataIn, skidData;

  assign acc = valid_i & ready_o;
  assign rel = valid_o & ready_i;

  assign mainCtrlIn = mainFromSkid ? skidCtrl : ctrl_i;
  assign mainDataIn = mainFromSkid ? skidData : data_i;

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)) uMain (
    .clk_i  (clk_i),
    .rst_ni (start_i),
    .load_i (mainLoad),
    .drop_i (mainDrop),
    .clear_i(clearAll),
    .ctrl_i (mainCtrlIn),
    .data_i (mainDataIn),
    .valid_o(mainValid),
    .ctrl_o (ctrl_o),
    .data_o (data_o)
  );

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)) uSkid (
    .clk_i  (clk_i),
    .rst_ni (start_i),
    .load_i (skidLoad),
    .drop_i (skidDrop),
    .clear_i(clearAll),
    .ctrl_i (ctrl_i),
    .data_i (data_i),
    .valid_o(skidValid),
    .ctrl_o (skidCtrl),
    .data_o (skidData)
  );

  // State register for the occupancy FSM.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  // Next state and entry controls; flush overrides every transfer.
  always_comb begin
    state_d      = state_q;
    mainLoad     = 1'b0;
    mainDrop     = 1'b0;
    mainFromSkid = 1'b0;
    skidLoad     = 1'b0;
    skidDrop     = 1'b0;
    clearAll     = 1'b0;
    if (flush_i) begin
      state_d  = EMPTY;
      clearAll = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d  = ONE;
            mainLoad = 1'b1;
          end
        end
        ONE: begin
          if (acc && rel) begin
            mainLoad = 1'b1;
          end else if (acc) begin
            state_d  = TWO;
            skidLoad = 1'b1;
          end else if (rel) begin
            state_d  = EMPTY;
            mainDrop = 1'b1;
          end
        end
        TWO: begin
          if (rel) begin
            state_d      = ONE;
            mainLoad     = 1'b1;
            mainFromSkid = 1'b1;
            skidDrop     = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Handshake and occupancy outputs, all derived from registered state.
  always_comb begin
    valid_o = mainValid;
    ready_o = start_i & ~skidValid;
    occ_o   = occOf(state_q);
  end

  // Saturating count of flushes that killed a held or incoming entry.
  always_comb begin
    flushCnt_d = flushCnt_q;
    if (flush_i && (state_q != EMPTY || valid_i) && flushCnt_q != {CNT_W{1'b1}})
      flushCnt_d = flushCnt_q + CNT_W'(1);
  end

  // Flush counter register.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) flushCnt_q <= '0;
    else          flushCnt_q <= flushCnt_d;
  end

  assign flush_cnt_o = flushCnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg, with a short randomised
// stretch checked against a reference FIFO queue.
module tb_pipe_stage_reg;

  localparam int CTRL_W = 8;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              start = 1'b0;
  logic              flush = 1'b0;
  logic              validIn = 1'b0;
  logic              readyOut;
  logic [CTRL_W-1:0] ctrlIn = '0;
  logic [DATA_W-1:0] dataIn = '0;
  logic              validOut;
  logic              readyIn = 1'b0;
  logic [CTRL_W-1:0] ctrlOut;
  logic [DATA_W-1:0] dataOut;
  logic [1:0]        occ;
  logic [CNT_W-1:0]  flushCnt;

  int testCount = 0;
  int failCount = 0;

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(1'b1), .CNT_W(CNT_W)) dut (
    .clk_i      (clk),
    .start_i    (start),
    .flush_i    (flush),
    .valid_i    (validIn),
    .ready_o    (readyOut),
    .ctrl_i     (ctrlIn),
    .data_i     (dataIn),
    .valid_o    (validOut),
    .ready_i    (readyIn),
    .ctrl_o     (ctrlOut),
    .data_o     (dataOut),
    .occ_o      (occ),
    .flush_cnt_o(flushCnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advances to one time unit after the next rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one upstream vector.
  task automatic applyStimulus(input logic v, input logic [CTRL_W-1:0] c,
                               input logic [DATA_W-1:0] d, input logic r, input logic f);
    validIn = v;
    ctrlIn  = c;
    dataIn  = d;
    readyIn = r;
    flush   = f;
  endtask

  logic [DATA_W-1:0] modelQ[$];
  logic [DATA_W-1:0] nextData;
  logic              mAcc, mRel;
  int                accepted, released;

  initial begin
    // Reset held for two cycles.
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    stepCycle();
    stepCycle();
    checkOutput("rst_valid", validOut, 0);
    checkOutput("rst_ready", readyOut, 0);
    checkOutput("rst_occ", occ, 0);
    checkOutput("rst_ctrl", ctrlOut, 0);
    checkOutput("rst_data", dataOut, 0);
    checkOutput("rst_cnt", flushCnt, 0);
    start = 1'b1;
    #1;
    checkOutput("rel_ready", readyOut, 1);

    // Streaming with ready held high: one-cycle latency, full throughput.
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, CTRL_W'(i), DATA_W'(i), 1'b1, 1'b0);
      stepCycle();
      checkOutput($sformatf("stream_data%0d", i), dataOut, i);
      checkOutput($sformatf("stream_ctrl%0d", i), ctrlOut, i);
      checkOutput($sformatf("stream_occ%0d", i), occ, 1);
      checkOutput($sformatf("stream_ready%0d", i), readyOut, 1);
    end
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
    stepCycle();
    checkOutput("drain_valid", validOut, 0);
    checkOutput("drain_ctrl", ctrlOut, 0);
    checkOutput("drain_data_held", dataOut, 3);
    checkOutput("drain_occ", occ, 0);

    // Back-pressure: two entries fill main and skid.
    applyStimulus(1'b1, 8'hA1, 32'h11, 1'b0, 1'b0);
    stepCycle();
    checkOutput("bp_occ1", occ, 1);
    applyStimulus(1'b1, 8'hA2, 32'h22, 1'b0, 1'b0);
    stepCycle();
    checkOutput("bp_occ2", occ, 2);
    checkOutput("bp_ready", readyOut, 0);
    checkOutput("bp_head", dataOut, 32'h11);
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    stepCycle();
    checkOutput("bp_hold_data", dataOut, 32'h11);
    checkOutput("bp_hold_ctrl", ctrlOut, 8'hA1);
    readyIn = 1'b1;
    #1;
    checkOutput("bp_no_comb_ready", readyOut, 0);
    stepCycle();
    checkOutput("bp_second", dataOut, 32'h22);
    checkOutput("bp_second_ctrl", ctrlOut, 8'hA2);
    checkOutput("bp_occ_after1", occ, 1);
    stepCycle();
    checkOutput("bp_occ_after2", occ, 0);
    checkOutput("bp_valid_after2", validOut, 0);

    // Flush with both entries full and a live incoming entry.
    applyStimulus(1'b1, 8'hB1, 32'h44, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 8'hB2, 32'h55, 1'b0, 1'b0);
    stepCycle();
    checkOutput("fl_pre_occ", occ, 2);
    applyStimulus(1'b1, 8'hFF, 32'h99, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
    checkOutput("fl_valid", validOut, 0);
    checkOutput("fl_ctrl", ctrlOut, 0);
    checkOutput("fl_data", dataOut, 0);
    checkOutput("fl_occ", occ, 0);
    checkOutput("fl_cnt", flushCnt, 1);
    checkOutput("fl_ready", readyOut, 1);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput($sformatf("fl_ghost%0d", i), validOut, 0);
    end

    // Flush while empty and idle is not counted.
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b1, 1'b1);
    stepCycle();
    checkOutput("fl_empty_cnt", flushCnt, 1);
    // Flush killing only the incoming entry counts; then saturation at 3.
    applyStimulus(1'b1, 8'hC1, 32'h66, 1'b1, 1'b1);
    stepCycle();
    checkOutput("fl_in_cnt", flushCnt, 2);
    checkOutput("fl_in_occ", occ, 0);
    stepCycle();
    checkOutput("fl_cnt_max", flushCnt, 3);
    applyStimulus(1'b1, 8'hC2, 32'h77, 1'b0, 1'b0);
    stepCycle();
    checkOutput("sat_pre_occ", occ, 1);
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 1'b1);
    stepCycle();
    checkOutput("sat_cnt", flushCnt, 3);
    checkOutput("sat_occ", occ, 0);
    flush = 1'b0;

    // Random traffic against a reference FIFO, mostly acc and rel together.
    modelQ.delete();
    nextData = 32'h1000;
    accepted = 0;
    released = 0;
    for (int i = 0; i < 100; i++) begin
      validIn = ($urandom_range(0, 7) != 0);
      readyIn = ($urandom_range(0, 5) != 0);
      dataIn  = nextData;
      ctrlIn  = nextData[CTRL_W-1:0];
      #1;
      checkOutput("rnd_ready", readyOut, (modelQ.size() < 2));
      mAcc = validIn && (modelQ.size() < 2);
      mRel = readyIn && (modelQ.size() > 0);
      stepCycle();
      if (mRel) begin
        void'(modelQ.pop_front());
        released++;
      end
      if (mAcc) begin
        modelQ.push_back(nextData);
        nextData = nextData + 1;
        accepted++;
      end
      checkOutput("rnd_occ", occ, modelQ.size());
      checkOutput("rnd_valid", validOut, (modelQ.size() > 0));
      if (modelQ.size() > 0) begin
        checkOutput("rnd_data", dataOut, modelQ[0]);
        checkOutput("rnd_ctrl", ctrlOut, modelQ[0][CTRL_W-1:0]);
      end else begin
        checkOutput("rnd_bubble_ctrl", ctrlOut, 0);
      end
    end
    checkOutput("rnd_balance", accepted - released, modelQ.size());

    // Asynchronous reset with two entries held.
    applyStimulus(1'b1, 8'hD1, 32'hAA, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) stepCycle();
    checkOutput("ar_pre_occ", occ, 2);
    flush = 1'b1;
    stepCycle();
    flush = 1'b0;
    applyStimulus(1'b1, 8'hD2, 32'hBB, 1'b0, 1'b0);
    stepCycle();
    stepCycle();
    checkOutput("ar_pre_occ2", occ, 2);
    checkOutput("ar_pre_cnt", flushCnt, 3);
    #2;
    start = 1'b0;
    #1;
    checkOutput("ar_valid", validOut, 0);
    checkOutput("ar_ctrl", ctrlOut, 0);
    checkOutput("ar_data", dataOut, 0);
    checkOutput("ar_occ", occ, 0);
    checkOutput("ar_cnt", flushCnt, 0);
    checkOutput("ar_ready", readyOut, 0);
    stepCycle();
    checkOutput("ar_ready_low", readyOut, 0);
    checkOutput("ar_occ_low", occ, 0);
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    start = 1'b1;
    #1;
    checkOutput("ar_ready_rel", readyOut, 1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "[TB] time limit reached");
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, generic pipeline-stage register that replaces the hand-written inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control field and a data payload from one stage to the next.
- Uses a valid/ready handshake with a 2-entry skid buffer, so downstream back-pressure never creates a combinational ready path.
- Supports synchronous flush for branch mispredict and keeps a saturating flush counter for performance debug.

Parameters:
- CTRL_W, 8: width of control field (RegWrite, MemRead, Branch, predict, ...). Zeroed on flush and on bubble.
- DATA_W, 128: width of payload (operands, immediate, PC, PC target, register addresses).
- CLEAR_DATA, 1: 1 means flush also zeroes stored data; 0 means data is left as-is (area saving).
- CNT_W, 16: width of the flush counter.

Ports:
- clk_i  in  1  rising-edge clock
- start_i  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous flush; kill all held and incoming entries
- valid_i  in  1  upstream entry valid
- ready_o  out  1  stage can accept an entry this cycle
- ctrl_i  in  CTRL_W  upstream control field
- data_i  in  DATA_W  upstream payload
- valid_o  out  1  entry presented downstream
- ready_i  in  1  downstream accepts this cycle
- ctrl_o  out  CTRL_W  control field of head entry
- data_o  out  DATA_W  payload of head entry
- occ_o  out  2  entries held: 0, 1 or 2
- flush_cnt_o  out  CNT_W  number of flush cycles that killed at least one entry; saturating

Behaviour:
- Reset (start_i low, asynchronous):
  - Both entries are invalid; ctrl and data registers are 0.
  - State is EMPTY; flush_cnt_o = 0.
  - valid_o = 0, ctrl_o = 0, data_o = 0, occ_o = 0.
  - ready_o is forced 0 while start_i is low.
- Transfers:
  - Accept: acc = valid_i & ready_o.
  - Release: rel = valid_o & ready_i.
- ready_o = start_i & ~skid_valid. It is a registered-state function only and never depends on ready_i.
- States (main = output entry, skid = overflow entry):
  - EMPTY: acc -> ONE, main <= input. Otherwise stay.
  - ONE:
    - acc & rel -> ONE, main <= input.
    - acc & ~rel -> TWO, skid <= input.
    - ~acc & rel -> EMPTY.
    - Neither -> hold.
  - TWO: rel -> ONE, main <= skid. ready_o = 0, so no accept is possible. Otherwise hold.
- Latency: an entry accepted in EMPTY appears on valid_o the next cycle. Throughput is 1 entry/cycle with ready_i held high.
- Ordering: strict FIFO; skid is never presented before main.
- Outputs:
  - valid_o = 1 in ONE and TWO.
  - ctrl_o and data_o always come from main.
  - In EMPTY, ctrl_o = 0 (bubble: all control deasserted). data_o holds its previous value, or 0 if CLEAR_DATA = 1 after a flush.
  - occ_o: EMPTY = 0, ONE = 1, TWO = 2.
- Flush (takes priority over every transfer):
  - Next state is EMPTY.
  - Main and skid ctrl are cleared to 0; data is cleared if CLEAR_DATA = 1.
  - Any valid_i on the same cycle is discarded: it is neither stored nor counted as accepted.
  - A rel on the flush cycle still completes, because downstream sampled it that cycle.
  - flush_cnt_o increments by 1 when occ_o != 0 or valid_i = 1, and saturates at all-ones.
- Flush in EMPTY with valid_i = 0: no state change, no count.
- Reset asserted mid-operation: immediate return to the reset values, including clearing flush_cnt_o.
- Held entries stay bit-stable while ready_i = 0: no glitch on ctrl_o or data_o.

Decomposition:
- Shared package pipe_pkg:
  - State enum {EMPTY, ONE, TWO}.
  - Occupancy encoding constants.
  - Default CTRL_W / DATA_W per stage boundary (IFID, IDEX, EXMEM, MEMWB localparams).
- One sub-module pipe_entry:
  - Holds one valid + ctrl + data register set.
  - Has load, clear and async reset.
  - Instanced twice (main, skid).
- FSM and counter live in the top.

Test Plan:
- Reset then stream: start_i low 2 cycles, then valid_i = 1, ready_i = 1, data_i = 1, 2, 3 on consecutive cycles -> data_o = 1, 2, 3 one cycle later each; occ_o = 1; ready_o stays 1.
- Back-pressure:
  - Entries A = 0x11 and B = 0x22 sent while ready_i = 0 -> occ_o = 2, ready_o = 0, data_o = 0x11 held stable.
  - ready_i = 1 -> 0x11, then 0x22 released in order; occ_o goes 2, 1, 0.
- Flush with both entries full and valid_i = 1 carrying ctrl = 0xFF -> next cycle valid_o = 0, ctrl_o = 0, occ_o = 0, flush_cnt_o = 1; the 0xFF entry never appears.
- Flush in EMPTY with valid_i = 0 -> flush_cnt_o unchanged. Force count to all-ones, then flush with data present -> stays saturated.
- Simultaneous acc & rel in ONE for 100 random cycles -> output sequence matches the scoreboard; no drop or duplicate; ready_o never depends on same-cycle ready_i.
- start_i pulsed low with occ_o = 2 -> outputs go to 0 asynchronously before the next clock edge; ready_o = 0 while low, then 1 after release.
